conversor_bin_bcd: RTL and testbench
====================================

# conversor_bin_bcd

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the per-digit 7-segment decoders. A start pulse latches an unsigned binary value. After WIDTH cycles the block presents DIGITS packed BCD nibbles, each of which drives one decoder's 4-bit `bin` input. Out-of-range values are flagged and forced to 4'hF per nibble, which the decoders render as the dash pattern.

## Interface
- WIDTH, default 8: width of the unsigned binary input; range 1–16.
- DIGITS, default 3: number of BCD output digits; range 1–5.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- start  in  1  request a conversion; honoured only in IDLE or DONE.
- bin  in  WIDTH  unsigned binary value; sampled only on the edge that accepts `start`.
- busy  out  1  high while a conversion is shifting (state SHIFT).
- done  out  1  one-cycle pulse; high exactly while in state DONE.
- bcd  out  4*DIGITS  result; nibble i = bcd[4i+3:4i] = decimal digit 10^i (nibble 0 = ones).
- overflow  out  1  set with the result when the latched value ≥ 10^DIGITS.

## Operation
- State machine: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on `start`.
  - SHIFT → DONE after WIDTH steps.
  - DONE → SHIFT if `start` is high, otherwise DONE → IDLE.
- Accept (start high in IDLE or DONE):
  - Load binary shift register with `bin`; clear the DIGITS-nibble scratch; load step counter = WIDTH.
  - Latch ovf_pend = (bin ≥ 10^DIGITS); the comparison uses a constant, computed at least DIGITS*4+1 bits wide.
- SHIFT step, once per edge:
  - Every scratch nibble ≥ 5 has 3 added, all nibbles in parallel.
  - Then {scratch, binary} shifts left by 1; the MSB of binary enters nibble 0 bit 0.
  - Counter decrements by 1.
- Final step (counter = 1): the post-step scratch is loaded into `bcd` on the same edge, and state → DONE.
  - If ovf_pend = 1, `bcd` loads all-4'hF and `overflow` = 1.
  - Otherwise `bcd` loads the scratch and `overflow` = 0.
- `bcd` and `overflow` are held unchanged until the next final-step edge or reset. Downstream decoders see stable digits between conversions.
- `start` in SHIFT is ignored; no queuing. Changes on `bin` after the accept edge are ignored.
- Reset (any state, including mid-SHIFT): state = IDLE, busy = 0, done = 0, bcd = 0, overflow = 0, counter and scratch cleared. An aborted conversion produces no `done` pulse.
- Reset has priority over `start` on the same edge.

## Timing
- Let E0 be the edge that accepts `start`.
- Steps occur on edges E1..E_WIDTH.
- `busy` = 1 for exactly WIDTH cycles (from after E0 to E_WIDTH).
- `bcd`/`overflow` are updated on E_WIDTH.
- `done` = 1 for exactly one cycle, between E_WIDTH and E_WIDTH+1.
- Latency: result valid WIDTH cycles after the accept edge (8 for default).
- Back-to-back: `start` high during the DONE cycle is accepted at E_WIDTH+1. Peak throughput is one conversion per WIDTH+1 cycles.
- `busy` and `done` are never high together.
- Outputs after reset release: busy = 0, done = 0, bcd = 0, overflow = 0.

## Test plan
- Reset, then start with bin=8'd0: busy high for 8 cycles; done pulses once 8 cycles after accept; bcd=12'h000, overflow=0.
- Start with bin=8'd255, then with 8'd99, 8'd100, 8'd9: bcd=12'h255, 12'h099, 12'h100, 12'h009 respectively, each with done exactly 8 edges after accept. Then exhaustively sweep 0–255 against a reference model.
- Start with bin=8'd37, then pulse start with bin=8'd200 at cycle 3 of SHIFT: second request ignored; bcd=12'h037. Then assert start with bin=8'd200 during the DONE cycle: accepted; bcd=12'h200 with done 9 cycles after the first done.
- Start with bin=8'd123, assert reset at SHIFT cycle 4: next cycle busy=0, bcd=12'h000, no done pulse. A fresh start with 8'd45 then gives bcd=12'h045.
- WIDTH=10, DIGITS=3 instance:
  - bin=10'd999 → bcd=12'h999, overflow=0.
  - bin=10'd1000 → bcd=12'hFFF, overflow=1.
  - bin=10'd1023 → bcd=12'hFFF, overflow=1.
  - Each with done 10 cycles after accept.
- Hold start high continuously with bin=8'd58: conversions repeat every 9 cycles; every done pulse shows bcd=12'h058; bcd is stable across the intervening SHIFT cycles.

Source files
------------

// File: rtl/conversor_bin_bcd.sv
// conversor_bin_bcd: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock. Results stay stable between conversions so the
// downstream 7-segment decoders never see intermediate digits. Values that do
// not fit in DIGITS decimal digits are flagged and shown as 4'hF per nibble.
module conversor_bin_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int LW   = BW + 1;
  localparam int CMPW = (WIDTH > LW) ? WIDTH : LW;

  // 10^n evaluated at elaboration; wide enough for both bin and 10^DIGITS
  function automatic logic [CMPW-1:0] pow10(input int n);
    logic [CMPW-1:0] p;
    p = CMPW'(1);
    for (int k = 0; k < n; k++) begin
      p = p * CMPW'(10);
    end
    return p;
  endfunction

  localparam logic [CMPW-1:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r, state_nx_s;
  logic [WIDTH-1:0]  bin_r, bin_nx_s;
  logic [BW-1:0]     scratch_r, scratch_nx_s, adj_s;
  logic [CW-1:0]     cnt_r, cnt_nx_s;
  logic              ovf_pend_r, ovf_pend_nx_s;
  logic [BW-1:0]     bcd_r, bcd_nx_s;
  logic              overflow_r, overflow_nx_s;
  logic              busy_r, busy_nx_s;
  logic              done_r, done_nx_s;
  logic [CMPW-1:0]   bin_ext_s;
  logic              ovf_s;

  assign bin_ext_s = CMPW'(bin);
  assign ovf_s     = (bin_ext_s >= LIMIT);

  // add-3 correction: every nibble >= 5 gets +3, all digits in parallel
  always_comb begin
    adj_s = scratch_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = scratch_r[4*i +: 4];
      end
    end
  end

  // next-state and datapath: accept, shift step, final-step result load
  always_comb begin
    state_nx_s    = state_r;
    bin_nx_s      = bin_r;
    scratch_nx_s  = scratch_r;
    cnt_nx_s      = cnt_r;
    ovf_pend_nx_s = ovf_pend_r;
    bcd_nx_s      = bcd_r;
    overflow_nx_s = overflow_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nx_s    = SHIFT;
          bin_nx_s      = bin;
          scratch_nx_s  = '0;
          cnt_nx_s      = CW'(WIDTH);
          ovf_pend_nx_s = ovf_s;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        scratch_nx_s = {adj_s[BW-2:0], bin_r[WIDTH-1]};
        bin_nx_s     = bin_r << 1'b1;
        cnt_nx_s     = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_nx_s = DONE;
          if (ovf_pend_r) begin
            bcd_nx_s      = {DIGITS{4'hF}};
            overflow_nx_s = 1'b1;
          end else begin
            bcd_nx_s      = scratch_nx_s;
            overflow_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = SHIFT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    busy_nx_s = (state_nx_s == SHIFT);
    done_nx_s = (state_nx_s == DONE);
  end

  // state and datapath registers; reset beats start on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      bin_r      <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= 1'b0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      bin_r      <= bin_nx_s;
      scratch_r  <= scratch_nx_s;
      cnt_r      <= cnt_nx_s;
      ovf_pend_r <= ovf_pend_nx_s;
      bcd_r      <= bcd_nx_s;
      overflow_r <= overflow_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Testbench for conversor_bin_bcd: an 8-bit and a 10-bit instance (3 digits)
// checked against a decimal reference model built from plain arithmetic.
module tb_conversor_bin_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  bin8 = 8'd0;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;
  logic        start10 = 1'b0;
  logic [9:0]  bin10 = 10'd0;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd10;

  logic        sel = 1'b0;
  logic        m_busy, m_done, m_ovf;
  logic [11:0] m_bcd;

  int n_cmp  = 0;
  int n_fail = 0;

  conversor_bin_bcd #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8)
  );

  conversor_bin_bcd #(.WIDTH(10), .DIGITS(3)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .bin(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10), .overflow(ovf10)
  );

  always #5 clk = ~clk;

  // observe whichever instance is under test
  always_comb begin
    if (sel) begin
      m_busy = busy10; m_done = done10; m_bcd = bcd10; m_ovf = ovf10;
    end else begin
      m_busy = busy8; m_done = done8; m_bcd = bcd8; m_ovf = ovf8;
    end
  end

  // decimal digits of v, or all-F with overflow when v needs a 4th digit
  function automatic logic [12:0] ref_model(input int v);
    if (v >= 1000) return {1'b1, 12'hFFF};
    return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called just after an edge; steps edges until done is seen (bounded)
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (m_done !== 1'b1 && lat < 40) begin
      if (m_busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input int v, input int w, input string tag);
    int lat, bc;
    logic [12:0] e;
    e = ref_model(v);
    @(negedge clk);
    if (sel) begin start10 = 1'b1; bin10 = 10'(v); end
    else begin start8 = 1'b1; bin8 = 8'(v); end
    @(posedge clk); #1;
    start8 = 1'b0;
    start10 = 1'b0;
    if (sel) bin10 = 10'($urandom);
    else bin8 = 8'($urandom);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, w);
    check({tag, " busy_cycles"}, bc, w);
    check({tag, " bcd"}, m_bcd, e[11:0]);
    check({tag, " overflow"}, m_ovf, e[12]);
    check({tag, " busy_with_done"}, m_busy, 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, m_done, 0);
    check({tag, " bcd_held"}, m_bcd, e[11:0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, cnt, last, seen;
    int vals[5] = '{0, 255, 99, 100, 9};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst bcd", bcd8, 0);
    check("rst overflow", ovf8, 0);
    check("rst bcd10", bcd10, 0);

    // directed values, then exhaustive sweep and random values
    foreach (vals[k]) run(vals[k], 8, $sformatf("dir%0d", vals[k]));
    for (int v = 0; v < 256; v++) run(v, 8, "sweep");
    for (int k = 0; k < 40; k++) run(int'($urandom_range(0, 255)), 8, "rand8");

    // start during SHIFT is ignored
    @(negedge clk); start8 = 1'b1; bin8 = 8'd37;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #1; start8 = 1'b0; bin8 = 8'd0;
    wait_done(lat, bc);
    check("ignore latency", lat + 3, 8);
    check("ignore bcd", bcd8, 12'h037);
    // start during DONE is accepted back-to-back
    start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #1; start8 = 1'b0; bin8 = 8'd7;
    wait_done(lat, bc);
    check("b2b done_spacing", lat + 1, 9);
    check("b2b bcd", bcd8, 12'h200);
    check("b2b overflow", ovf8, 0);
    @(posedge clk); #1;

    // reset during SHIFT aborts with no done
    @(negedge clk); start8 = 1'b1; bin8 = 8'd123;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort bcd", bcd8, 0);
    check("abort overflow", ovf8, 0);
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) cnt++; end
    check("abort no_done", cnt, 0);
    run(45, 8, "after_abort");

    // 10-bit instance: boundary around 10^3 plus random values
    sel = 1'b1;
    run(999, 10, "w10_999");
    run(1000, 10, "w10_1000");
    run(1023, 10, "w10_1023");
    run(0, 10, "w10_0");
    for (int k = 0; k < 20; k++) run(int'($urandom_range(0, 1023)), 10, "rand10");
    sel = 1'b0;

    // start held high: one conversion every WIDTH+1 cycles
    @(negedge clk); start8 = 1'b1; bin8 = 8'd58;
    last = -1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      check("hold busy_done_excl", busy8 & done8, 0);
      if (done8) begin
        check("hold bcd_at_done", bcd8, 12'h058);
        if (last >= 0) check("hold period", c - last, 9);
        last = c;
        seen++;
      end else if (last >= 0) begin
        check("hold bcd_stable", bcd8, 12'h058);
      end
    end
    check("hold done_count", seen, 6);
    start8 = 1'b0;
    repeat (12) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
